keypad_number_entry: RTL and testbench



---
 rtl/keypad_number_entry_if.sv | 25 ++
 rtl/keypad_number_entry.sv | 221 ++++++++++++++++++++++
 tb/tb_keypad_number_entry.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_number_entry_if.sv
// Keypad/number-entry bundle: keypad row/column lines plus the number
// register and key-event outputs that feed the display.
interface keypad_number_entry_if;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [23:0] number_sig;
    logic [3:0]  key_code;
    logic        key_valid;

    modport master (
        output col_in,
        input  row_out,
        input  number_sig,
        input  key_code,
        input  key_valid
    );

    modport slave (
        input  col_in,
        output row_out,
        output number_sig,
        output key_code,
        output key_valid
    );
endinterface

// File: rtl/keypad_number_entry.sv
// 4x4 matrix keypad scanner with frame-level debounce.
// Each accepted key is shifted into a six-digit hex number register.
module keypad_number_entry #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    keypad_number_entry_if.slave  bus
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CHECK     = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CHECK = 2'd3
    } state_t;

    function automatic logic [4:0] low_count(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Only meaningful when exactly one bit is set: the OR then equals its index.
    function automatic logic [3:0] low_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx = idx | (v[i] ? 4'(i) : 4'd0);
        end
        return idx;
    endfunction

    logic [3:0]       r_col_meta;
    logic [3:0]       r_col_sync;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_row;
    logic [3:0]       r_row_out;
    logic [11:0]      r_frame_low;
    state_t           r_state;
    logic [3:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [23:0]      r_number;
    logic [3:0]       r_key_code;
    logic             r_key_valid;

    logic             w_tick;
    logic             w_frame_done;
    logic [1:0]       w_row_next;
    logic [15:0]      w_frame_vec;
    logic [4:0]       w_low_cnt;
    logic [3:0]       w_code;
    logic             w_none;
    logic             w_single;
    logic [CNT_W-1:0] w_cnt_inc;
    state_t           w_state_next;
    logic [3:0]       w_cand_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_accept;

    assign w_tick       = (r_div == DIV_LAST);
    assign w_frame_done = w_tick && (r_row == 2'd3);
    assign w_row_next   = r_row + 2'd1;
    assign w_frame_vec  = {~r_col_sync, r_frame_low};
    assign w_low_cnt    = low_count(w_frame_vec);
    assign w_code       = low_index(w_frame_vec);
    assign w_none       = (w_low_cnt == 5'd0);
    assign w_single     = (w_low_cnt == 5'd1);
    assign w_cnt_inc    = r_cnt + CNT_W'(1);

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_meta <= 4'b1111;
            r_col_sync <= 4'b1111;
        end else begin
            r_col_meta <= bus.col_in;
            r_col_sync <= r_col_meta;
        end
    end

    // Row-slot divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Row advance and per-row column capture; row 3 is consumed directly at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row       <= 2'd0;
            r_row_out   <= 4'b1110;
            r_frame_low <= 12'd0;
        end else if (w_tick) begin
            r_row     <= w_row_next;
            r_row_out <= ~(4'b0001 << w_row_next);
            case (r_row)
                2'd0:    r_frame_low[3:0]  <= ~r_col_sync;
                2'd1:    r_frame_low[7:4]  <= ~r_col_sync;
                2'd2:    r_frame_low[11:8] <= ~r_col_sync;
                default: r_frame_low       <= r_frame_low;
            endcase
        end else begin
            r_row     <= r_row;
            r_row_out <= r_row_out;
        end
    end

    // Debounce state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cand  <= 4'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cand  <= w_cand_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Debounce next-state logic, evaluated once per completed frame.
    always_comb begin
        w_state_next = r_state;
        w_cand_next  = r_cand;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        if (w_frame_done) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_single) begin
                        w_state_next = ST_CHECK;
                        w_cand_next  = w_code;
                        w_cnt_next   = CNT_W'(1);
                    end else begin
                        w_cnt_next   = '0;
                    end
                end
                ST_CHECK: begin
                    if (w_single && (w_code == r_cand)) begin
                        if (w_cnt_inc == CNT_LAST) begin
                            w_state_next = ST_HELD;
                            w_cnt_next   = '0;
                            w_accept     = 1'b1;
                        end else begin
                            w_cnt_next   = w_cnt_inc;
                        end
                    end else begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end
                end
                ST_HELD: begin
                    if (w_none) begin
                        w_state_next = ST_REL_CHECK;
                        w_cnt_next   = CNT_W'(1);
                    end else begin
                        w_cnt_next   = '0;
                    end
                end
                ST_REL_CHECK: begin
                    if (w_none) begin
                        if (w_cnt_inc == CNT_LAST) begin
                            w_state_next = ST_IDLE;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next   = w_cnt_inc;
                        end
                    end else begin
                        w_state_next = ST_HELD;
                        w_cnt_next   = '0;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // Registered accept action: shift in the digit and pulse key_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_number    <= 24'h000000;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_number   <= {r_number[19:0], r_cand};
                r_key_code <= r_cand;
            end else begin
                r_number   <= r_number;
                r_key_code <= r_key_code;
            end
        end
    end

    assign bus.row_out    = r_row_out;
    assign bus.number_sig = r_number;
    assign bus.key_code   = r_key_code;
    assign bus.key_valid  = r_key_valid;

endmodule

// File: tb/tb_keypad_number_entry.sv
// Directed and randomized bench for keypad_number_entry; a frame-level
// keypad/debounce model predicts every key_valid pulse and the number register.
module tb_keypad_number_entry;

    localparam int SCAN_DIV = 4;
    localparam int DF       = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk;
    logic        rst_n;
    logic [15:0] press_mask;
    logic [3:0]  kp_col;

    int vectors;
    int miscompares;
    int pulses_seen;

    int          m_held;
    int          m_streak;
    logic [3:0]  m_cand;
    logic [23:0] m_num;
    logic [3:0]  m_code;

    keypad_number_entry_if kp_if ();

    keypad_number_entry #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        kp_col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kp_if.row_out[r] && press_mask[r*4+c]) kp_col[c] = 1'b0;
            end
        end
    end
    assign kp_if.col_in = kp_col;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held   = 0;
        m_streak = 0;
        m_cand   = 4'd0;
        m_num    = 24'd0;
        m_code   = 4'd0;
    endtask

    // One frame of the debounce rules; acc=1 when this frame accepts a key.
    task automatic model_frame(input logic [15:0] mask, output logic acc);
        int         n;
        logic [3:0] k;
        n   = $countones(mask);
        k   = 4'd0;
        acc = 1'b0;
        for (int i = 0; i < 16; i++) if (mask[i]) k = 4'(i);
        if (m_held == 0) begin
            if (n == 1 && m_streak > 0 && k == m_cand) m_streak++;
            else if (n == 1 && m_streak == 0) begin
                m_cand   = k;
                m_streak = 1;
            end else m_streak = 0;
            if (m_streak == DF) begin
                acc      = 1'b1;
                m_held   = 1;
                m_streak = 0;
                m_num    = m_num * 24'd16 + {20'd0, m_cand};
                m_code   = m_cand;
            end
        end else begin
            if (n == 0) begin
                m_streak++;
                if (m_streak == DF) begin
                    m_held   = 0;
                    m_streak = 0;
                end
            end else m_streak = 0;
        end
    endtask

    task automatic run_frame(input logic [15:0] mask);
        logic       acc;
        logic [3:0] one;
        int         r;
        one        = 4'b0001;
        press_mask = mask;
        model_frame(mask, acc);
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk);
            #1;
            r = ((i + 1) / SCAN_DIV) % 4;
            check("row_out", {28'd0, kp_if.row_out}, {28'd0, ~(one << r)});
            check("key_valid", {31'd0, kp_if.key_valid}, {31'd0, (i == FRAME - 1) ? acc : 1'b0});
            if (kp_if.key_valid === 1'b1) pulses_seen++;
        end
        check("number_sig", {8'd0, kp_if.number_sig}, {8'd0, m_num});
        check("key_code", {28'd0, kp_if.key_code}, {28'd0, m_code});
    endtask

    task automatic press(input logic [15:0] mask, input int n);
        for (int f = 0; f < n; f++) run_frame(mask);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row"}, {28'd0, kp_if.row_out}, 32'h0000000E);
        check({tag, "_num"}, {8'd0, kp_if.number_sig}, 32'h00000000);
        check({tag, "_code"}, {28'd0, kp_if.key_code}, 32'h00000000);
        check({tag, "_valid"}, {31'd0, kp_if.key_valid}, 32'h00000000);
    endtask

    initial begin
        int          p0;
        logic [15:0] mask;
        vectors     = 0;
        miscompares = 0;
        pulses_seen = 0;
        press_mask  = 16'h0000;
        rst_n       = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Two clean presses with full release between them.
        p0 = pulses_seen;
        press(16'h0020, 6);
        press(16'h0000, 4);
        check("t2_num_first", {8'd0, kp_if.number_sig}, 32'h00000005);
        check("t2_code_first", {28'd0, kp_if.key_code}, 32'h00000005);
        press(16'h0400, 6);
        press(16'h0000, 4);
        check("t2_num_second", {8'd0, kp_if.number_sig}, 32'h0000005A);
        check("t2_code_second", {28'd0, kp_if.key_code}, 32'h0000000A);
        check("t2_pulses", pulses_seen - p0, 32'd2);

        // Reset mid-scan with key 9 held through it.
        press_mask = 16'h0200;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        p0 = pulses_seen;
        press(16'h0200, 4);
        press(16'h0000, 4);
        check("t1_held_over_reset", pulses_seen - p0, 32'd1);
        check("t1_num", {8'd0, kp_if.number_sig}, 32'h00000009);

        // Bounce rejection.
        p0 = pulses_seen;
        for (int b = 0; b < 3; b++) begin
            press(16'h0008, 2);
            press(16'h0000, 1);
        end
        press(16'h0000, 3);
        check("t3_pulses", pulses_seen - p0, 32'd0);
        check("t3_num", {8'd0, kp_if.number_sig}, 32'h00000009);

        // Seven digits: the oldest falls off the top.
        p0 = pulses_seen;
        for (int k = 1; k <= 7; k++) begin
            mask = 16'h0001 << k;
            press(mask, 4);
            press(16'h0000, 4);
        end
        check("t4_pulses", pulses_seen - p0, 32'd7);
        check("t4_num", {8'd0, kp_if.number_sig}, 32'h00234567);
        check("t4_code", {28'd0, kp_if.key_code}, 32'h00000007);

        // Long hold, simultaneous keys, and a second key added while held.
        p0 = pulses_seen;
        press(16'h8000, 20);
        press(16'h0000, 4);
        check("t5_hold_pulses", pulses_seen - p0, 32'd1);
        p0 = pulses_seen;
        press(16'h0003, 10);
        press(16'h0000, 4);
        check("t5_multi_pulses", pulses_seen - p0, 32'd0);
        p0 = pulses_seen;
        press(16'h0002, 4);
        press(16'h0003, 3);
        press(16'h0000, 4);
        check("t5_add_pulses", pulses_seen - p0, 32'd1);
        check("t5_add_code", {28'd0, kp_if.key_code}, 32'h00000001);

        // Release bounce in HELD, then a fresh press of the same key.
        p0 = pulses_seen;
        press(16'h0100, 4);
        press(16'h0000, 1);
        press(16'h0100, 5);
        press(16'h0000, 4);
        check("t6_bounce_pulses", pulses_seen - p0, 32'd1);
        press(16'h0100, 4);
        press(16'h0000, 4);
        check("t6_repress_pulses", pulses_seen - p0, 32'd2);
        check("t6_code", {28'd0, kp_if.key_code}, 32'h00000008);

        // Randomized frames with persistence so presses often complete.
        mask = 16'h0000;
        for (int f = 0; f < 120; f++) begin
            if ($urandom_range(0, 99) >= 65) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: mask = 16'h0000;
                    4, 5, 6, 7, 8: mask = 16'h0001 << $urandom_range(0, 15);
                    default: mask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                endcase
            end
            run_frame(mask);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
